// File: rtl/wb_decode_pkg.sv
// Shared types for the Wishbone slave decoder: FSM states and the
// response code carried from ACTIVE/IDLE into the RESP cycle.
package wb_decode_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      NONE,
      ACK,
      ERR
   } resp_e;

endpackage

// File: rtl/wb_timeout.sv
// Slave response watchdog: counts enabled cycles after a clear and flags
// expiry when the count reaches TO-1, then holds there until cleared.
module wb_timeout
   import wb_decode_pkg::*;
#(
   parameter int TO = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = $clog2(TO);
   localparam logic [CW-1:0] LAST = CW'(TO - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/wb_slave_decode.sv
// Single-master Wishbone address decoder: registers the request, strobes one
// slave by the upper address bits and returns a registered one-cycle ack/err.
module wb_slave_decode
   import wb_decode_pkg::*;
#(
   parameter int MSK = 24,
   parameter int NS  = 4,
   parameter int TO  = 255,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int SW  = DW >> 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     i_wb_adr,
   input  logic [SW-1:0]     i_wb_sel,
   input  logic              i_wb_we,
   input  logic [DW-1:0]     i_wb_dat,
   output logic [DW-1:0]     o_wb_dat,
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   output logic              o_wb_ack,
   output logic              o_wb_err,
   output logic [AW-1:0]     o_s_adr,
   output logic [SW-1:0]     o_s_sel,
   output logic              o_s_we,
   output logic [DW-1:0]     o_s_dat,
   output logic [NS-1:0]     o_s_cyc,
   output logic [NS-1:0]     o_s_stb,
   input  logic [NS*DW-1:0]  i_s_dat,
   input  logic [NS-1:0]     i_s_ack,
   input  logic [NS-1:0]     i_s_err
);

   localparam int IW = (NS > 1) ? $clog2(NS) : 1;
   localparam int XW = AW - MSK;

   state_e         r_state;
   resp_e          r_code;
   logic [IW-1:0]  r_idx;
   logic [AW-1:0]  r_adr;
   logic [SW-1:0]  r_sel;
   logic           r_we;
   logic [DW-1:0]  r_wdat;
   logic [NS-1:0]  r_cyc;
   logic           r_ack;
   logic           r_err;
   logic [DW-1:0]  r_rdat;

   logic [XW-1:0]  w_idx_full;
   logic           w_mapped;
   logic [NS-1:0]  w_onehot;
   logic           w_accept;
   logic           w_s_ack;
   logic           w_s_err;
   logic [DW-1:0]  w_s_dat;
   logic           w_expired;

   assign w_idx_full = i_wb_adr[AW-1:MSK];
   assign w_mapped   = (32'(w_idx_full) < 32'(NS));

   always_comb begin
      w_onehot = '0;
      for (int k = 0; k < NS; k++) begin
         w_onehot[k] = (32'(w_idx_full) == k);
      end
   end

   // The response cycle itself blocks acceptance, so a master still holding
   // cyc/stb while it samples ack/err is not taken as a new request.
   assign w_accept = (r_state == IDLE) && i_wb_cyc && i_wb_stb && !r_ack && !r_err;

   assign w_s_ack = i_s_ack[r_idx];
   assign w_s_err = i_s_err[r_idx];
   assign w_s_dat = i_s_dat[r_idx*DW +: DW];

   wb_timeout #(.TO(TO)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_accept),
      .i_en      (r_state == ACTIVE),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_code  <= NONE;
         r_idx   <= '0;
         r_adr   <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_wdat  <= '0;
         r_cyc   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdat  <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_adr  <= i_wb_adr;
                  r_sel  <= i_wb_sel;
                  r_we   <= i_wb_we;
                  r_wdat <= i_wb_dat;
                  if (w_mapped) begin
                     r_idx   <= IW'(w_idx_full);
                     r_cyc   <= w_onehot;
                     r_state <= ACTIVE;
                  end else begin
                     r_code  <= ERR;
                     r_state <= RESP;
                  end
               end
            end
            ACTIVE: begin
               if (!i_wb_cyc) begin
                  r_cyc   <= '0;
                  r_state <= IDLE;
               end else if (w_s_err) begin
                  r_cyc   <= '0;
                  r_code  <= ERR;
                  r_state <= RESP;
               end else if (w_s_ack) begin
                  r_rdat  <= w_s_dat;
                  r_cyc   <= '0;
                  r_code  <= ACK;
                  r_state <= RESP;
               end else if (w_expired) begin
                  r_cyc   <= '0;
                  r_code  <= ERR;
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_ack   <= (r_code == ACK);
               r_err   <= (r_code == ERR);
               r_code  <= NONE;
               r_state <= IDLE;
            end
            default: begin
               r_cyc   <= '0;
               r_code  <= NONE;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_wb_dat = r_rdat;
   assign o_wb_ack = r_ack;
   assign o_wb_err = r_err;
   assign o_s_adr  = r_adr;
   assign o_s_sel  = r_sel;
   assign o_s_we   = r_we;
   assign o_s_dat  = r_wdat;
   assign o_s_cyc  = r_cyc;
   assign o_s_stb  = r_cyc;

endmodule

// File: tb/tb_wb_slave_decode.sv
// Directed bench for wb_slave_decode: one task per scenario, hand-derived
// cycle-by-cycle expectations, timeout shortened to 8 cycles.
module tb_wb_slave_decode;

   localparam int MSK = 24;
   localparam int NS  = 4;
   localparam int TO  = 8;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW >> 3;

   logic              clk;
   logic              rst;
   logic [AW-1:0]     wb_adr;
   logic [SW-1:0]     wb_sel;
   logic              wb_we;
   logic [DW-1:0]     wb_wdat;
   logic [DW-1:0]     wb_rdat;
   logic              wb_cyc;
   logic              wb_stb;
   logic              wb_ack;
   logic              wb_err;
   logic [AW-1:0]     s_adr;
   logic [SW-1:0]     s_sel;
   logic              s_we;
   logic [DW-1:0]     s_wdat;
   logic [NS-1:0]     s_cyc;
   logic [NS-1:0]     s_stb;
   logic [NS*DW-1:0]  s_rdat;
   logic [NS-1:0]     s_ack;
   logic [NS-1:0]     s_err;

   int n_vec;
   int n_err;

   wb_slave_decode #(
      .MSK(MSK), .NS(NS), .TO(TO), .AW(AW), .DW(DW), .SW(SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_wb_adr (wb_adr),
      .i_wb_sel (wb_sel),
      .i_wb_we  (wb_we),
      .i_wb_dat (wb_wdat),
      .o_wb_dat (wb_rdat),
      .i_wb_cyc (wb_cyc),
      .i_wb_stb (wb_stb),
      .o_wb_ack (wb_ack),
      .o_wb_err (wb_err),
      .o_s_adr  (s_adr),
      .o_s_sel  (s_sel),
      .o_s_we   (s_we),
      .o_s_dat  (s_wdat),
      .o_s_cyc  (s_cyc),
      .o_s_stb  (s_stb),
      .i_s_dat  (s_rdat),
      .i_s_ack  (s_ack),
      .i_s_err  (s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
      wb_adr  = a;
      wb_we   = we;
      wb_wdat = d;
      wb_sel  = 4'hF;
      wb_cyc  = 1'b1;
      wb_stb  = 1'b1;
   endtask

   task automatic release_master();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", wb_ack); end
      n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", wb_err); end
      n_vec++; if (wb_rdat !== 32'h0) begin n_err++; $display("FAIL reset_rdat got %h want 0", wb_rdat); end
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL reset_cyc got %b want 0000", s_cyc); end
      n_vec++; if (s_stb !== 4'b0000) begin n_err++; $display("FAIL reset_stb got %b want 0000", s_stb); end
      n_vec++; if (s_adr !== 32'h0) begin n_err++; $display("FAIL reset_adr got %h want 0", s_adr); end
      n_vec++; if (s_sel !== 4'h0) begin n_err++; $display("FAIL reset_sel got %h want 0", s_sel); end
      n_vec++; if (s_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", s_we); end
      n_vec++; if (s_wdat !== 32'h0) begin n_err++; $display("FAIL reset_wdat got %h want 0", s_wdat); end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Slot 1 acks one cycle after it sees cyc; master holds cyc while sampling ack.
   task automatic test_write();
      req(32'h0100_0000, 1'b1, 32'h0000_0003);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0010) begin n_err++; $display("FAIL wr_cyc got %b want 0010", s_cyc); end
      n_vec++; if (s_stb !== 4'b0010) begin n_err++; $display("FAIL wr_stb got %b want 0010", s_stb); end
      n_vec++; if (s_wdat !== 32'h3) begin n_err++; $display("FAIL wr_sdat got %h want 3", s_wdat); end
      n_vec++; if (s_adr !== 32'h0100_0000) begin n_err++; $display("FAIL wr_sadr got %h want 01000000", s_adr); end
      n_vec++; if (s_we !== 1'b1) begin n_err++; $display("FAIL wr_swe got %b want 1", s_we); end
      n_vec++; if (s_sel !== 4'hF) begin n_err++; $display("FAIL wr_ssel got %h want f", s_sel); end
      tick(); // e1
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_e1 got %b want 0", wb_ack); end
      s_ack = 4'b0010;
      tick(); // e2: ack sampled
      s_ack = 4'b0000;
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL wr_cyc_drop got %b want 0000", s_cyc); end
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_e2 got %b want 0", wb_ack); end
      tick(); // e3
      n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack_e3 got %b want 1", wb_ack); end
      n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL wr_err_e3 got %b want 0", wb_err); end
      tick(); // e4: request still present, must not be re-accepted
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_e4 got %b want 0", wb_ack); end
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL wr_reaccept got %b want 0000", s_cyc); end
      n_vec++; if (wb_rdat !== 32'h0) begin n_err++; $display("FAIL wr_rdat got %h want 0", wb_rdat); end
      release_master();
      tick();
   endtask

   // Other slots respond first and must be ignored; slot 0 returns 2.
   task automatic test_read();
      req(32'h0000_0010, 1'b0, 32'h0);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0001) begin n_err++; $display("FAIL rd_cyc got %b want 0001", s_cyc); end
      n_vec++; if (s_we !== 1'b0) begin n_err++; $display("FAIL rd_swe got %b want 0", s_we); end
      s_rdat[1*DW +: DW] = 32'hDEAD_BEEF;
      s_ack = 4'b0010;
      s_err = 4'b0100;
      tick(); // e1
      s_ack = 4'b0000;
      s_err = 4'b0000;
      n_vec++; if (s_cyc !== 4'b0001) begin n_err++; $display("FAIL rd_ignore got %b want 0001", s_cyc); end
      s_rdat[0*DW +: DW] = 32'h0000_0002;
      s_ack = 4'b0001;
      tick(); // e2
      s_ack = 4'b0000;
      s_rdat[0*DW +: DW] = 32'hFFFF_FFFF;
      tick(); // e3
      n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack got %b want 1", wb_ack); end
      n_vec++; if (wb_rdat !== 32'h2) begin n_err++; $display("FAIL rd_dat got %h want 2", wb_rdat); end
      release_master();
      tick(); // e4
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_end got %b want 0", wb_ack); end
      n_vec++; if (wb_rdat !== 32'h2) begin n_err++; $display("FAIL rd_dat_hold got %h want 2", wb_rdat); end
      tick();
   endtask

   task automatic test_unmapped();
      req(32'h0700_0000, 1'b0, 32'h0);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL um_cyc got %b want 0000", s_cyc); end
      n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL um_err_e0 got %b want 0", wb_err); end
      tick(); // e1
      n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL um_err_e1 got %b want 1", wb_err); end
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL um_ack got %b want 0", wb_ack); end
      release_master();
      tick(); // e2
      n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL um_err_e2 got %b want 0", wb_err); end
      tick();
   endtask

   task automatic test_timeout();
      s_rdat[2*DW +: DW] = 32'h5555_AAAA;
      req(32'h0200_0000, 1'b0, 32'h0);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0100) begin n_err++; $display("FAIL to_cyc_e0 got %b want 0100", s_cyc); end
      for (int i = 1; i < TO; i++) begin
         tick();
         n_vec++; if (s_cyc !== 4'b0100 || wb_err !== 1'b0) begin n_err++; $display("FAIL to_wait_e%0d got cyc=%b err=%b want 0100/0", i, s_cyc, wb_err); end
      end
      tick(); // e8
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL to_cyc_drop got %b want 0000", s_cyc); end
      n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL to_err_e8 got %b want 0", wb_err); end
      tick(); // e9
      n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL to_err_e9 got %b want 1", wb_err); end
      n_vec++; if (wb_rdat !== 32'h2) begin n_err++; $display("FAIL to_rdat got %h want 2", wb_rdat); end
      release_master();
      tick(); // e10
      n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL to_err_e10 got %b want 0", wb_err); end
      tick();
   endtask

   task automatic test_ack_err_both();
      req(32'h0300_0000, 1'b0, 32'h0);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b1000) begin n_err++; $display("FAIL ae_cyc got %b want 1000", s_cyc); end
      s_rdat[3*DW +: DW] = 32'h1234_5678;
      s_ack = 4'b1000;
      s_err = 4'b1000;
      tick(); // e1
      s_ack = 4'b0000;
      s_err = 4'b0000;
      tick(); // e2
      n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL ae_err got %b want 1", wb_err); end
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL ae_ack got %b want 0", wb_ack); end
      release_master();
      tick();
      tick();
   endtask

   task automatic test_abort();
      req(32'h0100_0004, 1'b0, 32'h0);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0010) begin n_err++; $display("FAIL ab_cyc got %b want 0010", s_cyc); end
      release_master();
      tick(); // e1
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL ab_cyc_drop got %b want 0000", s_cyc); end
      for (int i = 2; i < 5; i++) begin
         tick();
         n_vec++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin n_err++; $display("FAIL ab_resp_e%0d got ack=%b err=%b want 0/0", i, wb_ack, wb_err); end
      end
   endtask

   task automatic test_reset_active();
      req(32'h0100_0008, 1'b1, 32'h0000_00AB);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0010) begin n_err++; $display("FAIL ra_cyc got %b want 0010", s_cyc); end
      #2;
      rst = 1'b1;
      #1;
      n_vec++; if (s_cyc !== 4'b0000) begin n_err++; $display("FAIL ra_cyc_rst got %b want 0000", s_cyc); end
      n_vec++; if (s_adr !== 32'h0) begin n_err++; $display("FAIL ra_adr_rst got %h want 0", s_adr); end
      n_vec++; if (s_wdat !== 32'h0) begin n_err++; $display("FAIL ra_sdat_rst got %h want 0", s_wdat); end
      n_vec++; if (wb_rdat !== 32'h0) begin n_err++; $display("FAIL ra_rdat_rst got %h want 0", wb_rdat); end
      release_master();
      tick();
      rst = 1'b0;
      tick();
      req(32'h0100_0000, 1'b0, 32'h0);
      tick(); // e0
      n_vec++; if (s_cyc !== 4'b0010) begin n_err++; $display("FAIL ra2_cyc got %b want 0010", s_cyc); end
      s_rdat[1*DW +: DW] = 32'hCAFE_0001;
      s_ack = 4'b0010;
      tick(); // e1
      s_ack = 4'b0000;
      tick(); // e2
      n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL ra2_ack got %b want 1", wb_ack); end
      n_vec++; if (wb_rdat !== 32'hCAFE_0001) begin n_err++; $display("FAIL ra2_dat got %h want cafe0001", wb_rdat); end
      release_master();
      tick(); // e3
      n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL ra2_ack_end got %b want 0", wb_ack); end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      wb_adr  = '0;
      wb_sel  = '0;
      wb_we   = 1'b0;
      wb_wdat = '0;
      wb_cyc  = 1'b0;
      wb_stb  = 1'b0;
      s_rdat  = '0;
      s_ack   = '0;
      s_err   = '0;
      test_reset();
      test_write();
      test_read();
      test_unmapped();
      test_timeout();
      test_ack_err_both();
      test_abort();
      test_reset_active();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
